adc_capture_packer: RTL
=======================

# adc_capture_packer

- Parametrised ADC capture front-end for hsdaoh designs; generalises the fixed dual-12-bit capture to NUM_CH channels of SAMPLE_W bits.
- Adds a per-channel enable mask, input decimation and a counter test-pattern mode.
- Packs the samples of enabled channels densely into OUT_W-bit words, so disabling channels lowers the FIFO write rate instead of wasting bandwidth.
- Sits in the ADC clock domain directly in front of the async_fifo write port and reports and counts words dropped on FIFO full.

## Interface
Parameters:
- NUM_CH, 2, channel count, 1..8
- SAMPLE_W, 12, bits per sample, 8..16
- OUT_W, NUM_CH*SAMPLE_W, output word width; fixed to NUM_CH*SAMPLE_W, giving NUM_CH slots per word

Ports:
- clk  in  1  ADC/data clock; all logic on its rising edge
- rstn  in  1  asynchronous active-low reset
- adc_data  in  NUM_CH*SAMPLE_W  raw samples; channel 0 in MSBs
- capture_en  in  1  capture run control
- ch_en  in  NUM_CH  channel enable mask; latched at capture start
- decim  in  8  keep 1 of every decim+1 input cycles; latched at capture start
- test_mode  in  1  replace samples with counter pattern; latched at capture start
- fifo_full  in  1  FIFO full flag, same clock
- wr_en  out  1  FIFO write strobe
- wr_data  out  OUT_W  packed word; slot 0 in MSBs
- ovf  out  1  sticky overflow flag
- ovf_cnt  out  16  dropped-word count, saturating at 0xFFFF
- ovf_clr  in  1  clears ovf and ovf_cnt

## Operation
- Reset:
  - wr_en=0, wr_data=0, ovf=0, ovf_cnt=0.
  - Latched config is cleared: mask 0, decim 0, test_mode 0.
  - fill=0, decimation counter=0, pattern counter=0.
- Capture start:
  - Triggered by a capture_en rising edge, detected against a registered copy of capture_en.
  - Latches ch_en, decim and test_mode.
  - Clears fill, the decimation counter and the pattern counter.
- Run:
  - A kept cycle is one where the decimation counter is 0; the counter counts 0..decim then wraps.
  - On each kept cycle, K = popcount(latched mask) samples are appended in ascending channel order.
  - In test_mode, each appended sample is the pattern counter value, which then increments by 1 (SAMPLE_W bits, wraps).
- Packing:
  - Slot buffer holds fill (0..NUM_CH-1) pending samples.
  - Appending K samples with fill+K >= NUM_CH emits one word made of the first NUM_CH slots. The remaining fill+K-NUM_CH samples carry over into slots 0.. of the next word.
  - Since K <= NUM_CH, at most one word is emitted per cycle.
- Stop:
  - capture_en low stops appending.
  - A partial word (fill>0) is discarded and fill cleared.
  - Emission of a word whose last sample was appended on the final high cycle still completes.
- K=0: nothing is ever emitted.
- Overflow:
  - A word due for emission while fifo_full=1 is dropped: wr_en stays 0, ovf is set, ovf_cnt increments (saturating).
  - Packer state advances exactly as if the word had been written.
- ovf_clr and an overflow in the same cycle: the result is ovf=1, ovf_cnt=1.
- Config inputs are ignored while capture_en is high.

## Timing
- adc_data is registered on input (stage 1); packing and emission are registered (stage 2).
- A sample presented at edge N appears in wr_data with wr_en high after edge N+2, if its word completes at that append.
- wr_en is a single-cycle strobe per word. With all channels enabled and decim=0 it is continuously high.
- fifo_full is sampled in the same cycle as the emission decision (stage 2). No backpressure into the ADC path.
- Throughput: words/cycle = K / (NUM_CH*(decim+1)).
- ovf and ovf_cnt update one cycle after the dropped emission.

## Structure
- Package hsdaoh_capture_pkg holds:
  - MAX_CH = 8
  - OVF_CNT_W = 16
  - function popcount(mask)
  - function slot(word, i), which returns the SAMPLE_W-bit field i, MSB-first
- Sub-module sample_gearbox holds the slot buffer, fill counter and emission logic. It takes K samples per strobe and outputs a word strobe.
- Top-level logic holds the input register, config latch, decimation counter, test pattern mux and overflow counter.

## Test plan
- NUM_CH=2, SAMPLE_W=12, mask 11, decim 0, adc_data {0xABC,0x123} -> wr_en every cycle from edge 3 on, wr_data 0xABC123.
- Mask 01 (channel 1 only), channel 1 ramps 0,1,2,3 -> wr_en every 2nd cycle, words 0x000001 then 0x002003.
- NUM_CH=4, mask 0111, test_mode, decim 0 -> words 0x000,0x001,0x002,0x003 | 0x004..0x007 ...; 3 words per 4 kept cycles, pattern continuous, no gaps.
- decim=2, mask 11, test_mode -> one word every 3 cycles, values 0x000001, 0x002003, ...
- fifo_full high for 5 emission slots -> no wr_en in that window, ovf=1, ovf_cnt=5; ovf_clr with a simultaneous drop -> ovf_cnt=1.
- rstn low mid-word with mask 01, fill=1 -> all outputs 0 immediately. After rstn rises, the next capture start yields a first word made of two fresh samples only.

Source files
------------

// File: rtl/adc_capture_packer_pkg.sv
// Shared constants, stage flags and helpers for the ADC capture packer.
// popcount() sizes the per-cycle append; slot() extracts MSB-first fields.
package hsdaoh_capture_pkg;

  localparam int MAX_CH    = 8;
  localparam int MAX_SW    = 16;
  localparam int OVF_CNT_W = 16;
  localparam int CNT_W     = 4;

  typedef struct packed {
    logic run;
    logic first;
    logic keep;
  } s1_flags_t;

  function automatic logic [CNT_W-1:0] popcount(
    input logic [MAX_CH-1:0] mask
  );
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_CH; i++)
      n = n + CNT_W'(mask[i]);
    return n;
  endfunction

  // Field i of an n-slot word of sw-bit fields, slot 0 in the MSBs.
  function automatic logic [MAX_SW-1:0] slot(
    input logic [MAX_CH*MAX_SW-1:0] word,
    input int                       i,
    input int                       n,
    input int                       sw
  );
    logic [MAX_CH*MAX_SW-1:0] sh;
    logic [MAX_SW:0]          m;
    sh = word >> ((n - 1 - i) * sw);
    m  = (17'(1) << sw) - 17'(1);
    return sh[MAX_SW-1:0] & m[MAX_SW-1:0];
  endfunction

endpackage

// File: rtl/adc_capture_packer_if.sv
// FIFO write-port bundle between the packer and the async FIFO.
// master drives wr_en/wr_data and watches fifo_full; slave is the FIFO.
interface adc_capture_packer_if #(
  parameter int OUT_W = 24
);
  logic             wr_en;
  logic [OUT_W-1:0] wr_data;
  logic             fifo_full;

  modport master (
    output wr_en,
    output wr_data,
    input  fifo_full
  );

  modport slave (
    input  wr_en,
    input  wr_data,
    output fifo_full
  );
endinterface

// File: rtl/adc_capture_packer_gearbox.sv
// sample_gearbox: slot buffer + fill counter; packs K samples per strobe.
// In: stb_i/clr_i/k_i/smp_i (compacted, slot 0 MSB). Out: word_stb_o/word_o.
module sample_gearbox
  import hsdaoh_capture_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       stb_i,
  input  logic                       clr_i,
  input  logic [CNT_W-1:0]           k_i,
  input  logic [NUM_CH*SAMPLE_W-1:0] smp_i,
  output logic                       word_stb_o,
  output logic [NUM_CH*SAMPLE_W-1:0] word_o
);

  localparam int W = NUM_CH * SAMPLE_W;

  logic [SAMPLE_W-1:0] slots_q [NUM_CH];
  logic [SAMPLE_W-1:0] slots_d [NUM_CH];
  logic [SAMPLE_W-1:0] cat     [2*NUM_CH];
  logic [CNT_W-1:0]    fill_q, fill_d;
  logic [W-1:0]        word_q, word_d;
  logic                stb_q, stb_d;
  int                  base, total;

  // cat = pending slots followed by this cycle's samples.
  // clr_i restarts the buffer while still taking the strobe.
  always_comb begin
    base  = clr_i ? 0 : int'(fill_q);
    total = base + (stb_i ? int'(k_i) : 0);
    for (int i = 0; i < 2*NUM_CH; i++) begin
      cat[i] = '0;
      if (i < base)
        cat[i] = slots_q[i % NUM_CH];
      else if (i < total)
        cat[i] = smp_i[(NUM_CH-1-(i-base))*SAMPLE_W +: SAMPLE_W];
    end
    stb_d  = 1'b0;
    word_d = word_q;
    fill_d = CNT_W'(total);
    for (int i = 0; i < NUM_CH; i++)
      slots_d[i] = cat[i];
    if (total >= NUM_CH) begin
      stb_d  = 1'b1;
      fill_d = CNT_W'(total - NUM_CH);
      for (int i = 0; i < NUM_CH; i++) begin
        word_d[(NUM_CH-1-i)*SAMPLE_W +: SAMPLE_W] = cat[i];
        slots_d[i] = cat[NUM_CH+i];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fill_q <= '0;
      word_q <= '0;
      stb_q  <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        slots_q[i] <= '0;
    end else begin
      fill_q <= fill_d;
      word_q <= word_d;
      stb_q  <= stb_d;
      for (int i = 0; i < NUM_CH; i++)
        slots_q[i] <= slots_d[i];
    end
  end

  assign word_stb_o = stb_q;
  assign word_o     = word_q;

endmodule

// File: rtl/adc_capture_packer.sv
// ADC capture front-end: mask/decimate/test-pattern, dense word packing.
// Ports: clk, rstn, adc_data, capture_en, ch_en, decim, test_mode,
//   fifo (master: wr_en, wr_data, fifo_full), ovf, ovf_cnt, ovf_clr.
//   ch_en/adc_data are MSB-first: channel c is bit/field NUM_CH-1-c.
module adc_capture_packer
  import hsdaoh_capture_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 12,
  parameter int OUT_W    = NUM_CH * SAMPLE_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_CH*SAMPLE_W-1:0] adc_data,
  input  logic                       capture_en,
  input  logic [NUM_CH-1:0]          ch_en,
  input  logic [7:0]                 decim,
  input  logic                       test_mode,
  adc_capture_packer_if.master       fifo,
  output logic                       ovf,
  output logic [OVF_CNT_W-1:0]       ovf_cnt,
  input  logic                       ovf_clr
);

  localparam int IN_W = NUM_CH * SAMPLE_W;

  logic                cap_q;
  logic                start;
  logic [NUM_CH-1:0]   mask_q;
  logic [7:0]          decim_q;
  logic                tm_q;
  logic [7:0]          dcnt_q, dcnt_d;
  logic [7:0]          cnt_cur, cfg_decim;
  logic [IN_W-1:0]     adc_q;
  s1_flags_t           s1_q, s1_d;

  logic [IN_W-1:0]     smp_q, smp_d;
  logic [CNT_W-1:0]    k_q, k_d;
  logic                stb_q, clr_q;
  logic [SAMPLE_W-1:0] pat_q, pat_d, pat_base;
  logic [MAX_CH*MAX_SW-1:0] wide;
  logic [MAX_SW-1:0]   sv;
  logic [SAMPLE_W-1:0] chv;
  int                  idx;

  logic                gb_stb;
  logic [IN_W-1:0]     gb_word;
  logic                drop;
  logic                ovf_q, ovf_d;
  logic [OVF_CNT_W-1:0] cnt_q, cnt_d;

  assign start = capture_en & ~cap_q;

  // Stage 1: on start the counter is treated as already cleared.
  always_comb begin
    cfg_decim  = start ? decim : decim_q;
    cnt_cur    = start ? 8'd0 : dcnt_q;
    s1_d.run   = capture_en;
    s1_d.first = start;
    s1_d.keep  = capture_en && (cnt_cur == 8'd0);
    dcnt_d     = 8'd0;
    if (capture_en)
      dcnt_d = (cnt_cur == cfg_decim) ? 8'd0 : cnt_cur + 8'd1;
  end

  // Compaction of enabled channels into slots 0..K-1.
  always_comb begin
    pat_base = s1_q.first ? '0 : pat_q;
    wide     = '0;
    wide[IN_W-1:0] = adc_q;
    smp_d    = '0;
    sv       = '0;
    chv      = '0;
    idx      = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mask_q[NUM_CH-1-c]) begin
        sv  = slot(wide, c, NUM_CH, SAMPLE_W);
        chv = tm_q ? pat_base + SAMPLE_W'(idx)
                   : sv[SAMPLE_W-1:0];
        smp_d[(NUM_CH-1-idx)*SAMPLE_W +: SAMPLE_W] = chv;
        idx = idx + 1;
      end
    end
    k_d   = popcount(MAX_CH'(mask_q));
    pat_d = pat_base;
    if (s1_q.keep && tm_q)
      pat_d = pat_base + SAMPLE_W'(k_d);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cap_q   <= 1'b0;
      mask_q  <= '0;
      decim_q <= '0;
      tm_q    <= 1'b0;
      dcnt_q  <= '0;
      adc_q   <= '0;
      s1_q    <= '0;
      smp_q   <= '0;
      k_q     <= '0;
      stb_q   <= 1'b0;
      clr_q   <= 1'b0;
      pat_q   <= '0;
    end else begin
      cap_q  <= capture_en;
      if (start) begin
        mask_q  <= ch_en;
        decim_q <= decim;
        tm_q    <= test_mode;
      end
      dcnt_q <= dcnt_d;
      adc_q  <= adc_data;
      s1_q   <= s1_d;
      smp_q  <= smp_d;
      k_q    <= k_d;
      stb_q  <= s1_q.keep;
      // idle or restart flushes any partial word in the gearbox
      clr_q  <= s1_q.first | ~s1_q.run;
      pat_q  <= pat_d;
    end
  end

  sample_gearbox #(
    .NUM_CH   (NUM_CH),
    .SAMPLE_W (SAMPLE_W)
  ) u_gearbox (
    .clk        (clk),
    .rstn       (rstn),
    .stb_i      (stb_q),
    .clr_i      (clr_q),
    .k_i        (k_q),
    .smp_i      (smp_q),
    .word_stb_o (gb_stb),
    .word_o     (gb_word)
  );

  // A full FIFO drops the word; the gearbox has already moved on.
  assign drop         = gb_stb & fifo.fifo_full;
  assign fifo.wr_en   = gb_stb & ~fifo.fifo_full;
  assign fifo.wr_data = gb_word;

  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)
        cnt_d = OVF_CNT_W'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + OVF_CNT_W'(1);
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign ovf     = ovf_q;
  assign ovf_cnt = cnt_q;

endmodule
